// File: rtl/opb_cfg_pkg.sv
// Shared types for the OPB configuration master: FSM states, response codes
// and counter sizing.
package opb_cfg_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUS,
        S_BACKOFF,
        S_RESP
    } state_t;

    typedef enum logic [2:0] {
        ST_OK      = 3'd0,
        ST_ERR     = 3'd1,
        ST_TIMEOUT = 3'd2,
        ST_RETRY   = 3'd3,
        ST_ADDR    = 3'd4
    } status_t;

    // Bits needed to hold values 0..max_val, never less than one.
    function automatic int cnt_width(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

    localparam int DEF_TIMEOUT   = 16;
    localparam int DEF_MAX_RETRY = 4;
    localparam int TOUT_W_DEF    = cnt_width(DEF_TIMEOUT - 1);
    localparam int RETRY_W_DEF   = cnt_width(DEF_MAX_RETRY);

endpackage

// File: rtl/opb_cfg_addr_check.sv
// Combinational inclusive address-window compare for OPB masters.
module opb_cfg_addr_check #(
    parameter logic [31:0] C_BASEADDR = 32'h010B0000,
    parameter logic [31:0] C_HIGHADDR = 32'h010B00FF
) (
    input  logic [31:0] addr,
    output logic        in_window
);

    assign in_window = (addr >= C_BASEADDR) && (addr <= C_HIGHADDR);

endmodule

// File: rtl/opb_reg_cfg_sequencer.sv
// Single-outstanding OPB master: one command in, one bus transaction (with
// retry/backoff and timeout), one status/data response out.
module opb_reg_cfg_sequencer
    import opb_cfg_pkg::*;
#(
    parameter logic [31:0] C_BASEADDR  = 32'h010B0000,
    parameter logic [31:0] C_HIGHADDR  = 32'h010B00FF,
    parameter int          C_TIMEOUT   = DEF_TIMEOUT,
    parameter int          C_MAX_RETRY = DEF_MAX_RETRY
) (
    input  logic        OPB_Clk,
    input  logic        OPB_Rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_rnw,
    input  logic [31:0] cmd_addr,
    input  logic [31:0] cmd_data,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [2:0]  rsp_status,
    output logic [31:0] rsp_data,
    output logic [0:31] M_ABus,
    output logic [0:3]  M_BE,
    output logic [0:31] M_DBus,
    output logic        M_RNW,
    output logic        M_select,
    output logic        M_seqAddr,
    input  logic [0:31] Sl_DBus,
    input  logic        Sl_xferAck,
    input  logic        Sl_errAck,
    input  logic        Sl_retry,
    input  logic        Sl_toutSup
);

    localparam int TOUT_W  = cnt_width(C_TIMEOUT - 1);
    localparam int RETRY_W = cnt_width(C_MAX_RETRY);
    localparam logic [TOUT_W-1:0]  TOUT_LAST = TOUT_W'(C_TIMEOUT - 1);
    localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(C_MAX_RETRY);

    state_t               state;
    logic [TOUT_W-1:0]    tout_cnt;
    logic [RETRY_W-1:0]   retry_cnt;
    logic                 rnw_q;
    logic [31:0]          addr_q;
    logic [31:0]          data_q;
    logic                 in_window;
    logic                 accept;
    logic                 tout_fire;
    logic                 bus_exit;

    opb_cfg_addr_check #(
        .C_BASEADDR (C_BASEADDR),
        .C_HIGHADDR (C_HIGHADDR)
    ) u_addr_check (
        .addr      (cmd_addr),
        .in_window (in_window)
    );

    assign M_seqAddr = 1'b0;
    assign accept    = (state == S_IDLE) && cmd_valid && cmd_ready;
    // A suppressed cycle can never time out; the counter is frozen then.
    assign tout_fire = !Sl_toutSup && (tout_cnt == TOUT_LAST);
    assign bus_exit  = Sl_errAck || Sl_xferAck || Sl_retry || tout_fire;

    // Command hold registers are pure data; BACKOFF re-drives the bus from them.
    always_ff @(posedge OPB_Clk) begin
        if (accept) begin
            rnw_q  <= cmd_rnw;
            addr_q <= cmd_addr;
            data_q <= cmd_data;
        end
    end

    always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
        if (!OPB_Rst_n) begin
            state      <= S_IDLE;
            tout_cnt   <= '0;
            retry_cnt  <= '0;
            cmd_ready  <= 1'b1;
            rsp_valid  <= 1'b0;
            rsp_status <= '0;
            rsp_data   <= '0;
            M_ABus     <= '0;
            M_BE       <= '0;
            M_DBus     <= '0;
            M_RNW      <= 1'b0;
            M_select   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        cmd_ready <= 1'b0;
                        tout_cnt  <= '0;
                        retry_cnt <= '0;
                        if (in_window) begin
                            state    <= S_BUS;
                            M_select <= 1'b1;
                            M_ABus   <= cmd_addr;
                            M_BE     <= 4'b1111;
                            M_DBus   <= cmd_rnw ? 32'd0 : cmd_data;
                            M_RNW    <= cmd_rnw;
                        end else begin
                            state      <= S_RESP;
                            rsp_valid  <= 1'b1;
                            rsp_status <= ST_ADDR;
                            rsp_data   <= '0;
                        end
                    end
                end

                S_BUS: begin
                    if (bus_exit) begin
                        M_select <= 1'b0;
                        M_ABus   <= '0;
                        M_BE     <= '0;
                        M_DBus   <= '0;
                        M_RNW    <= 1'b0;
                    end
                    if (Sl_errAck) begin
                        state      <= S_RESP;
                        rsp_valid  <= 1'b1;
                        rsp_status <= ST_ERR;
                        rsp_data   <= '0;
                    end else if (Sl_xferAck) begin
                        state      <= S_RESP;
                        rsp_valid  <= 1'b1;
                        rsp_status <= ST_OK;
                        rsp_data   <= rnw_q ? Sl_DBus : 32'd0;
                    end else if (Sl_retry) begin
                        if (retry_cnt < RETRY_MAX) begin
                            retry_cnt <= retry_cnt + RETRY_W'(1);
                            state     <= S_BACKOFF;
                        end else begin
                            state      <= S_RESP;
                            rsp_valid  <= 1'b1;
                            rsp_status <= ST_RETRY;
                            rsp_data   <= '0;
                        end
                    end else if (tout_fire) begin
                        state      <= S_RESP;
                        rsp_valid  <= 1'b1;
                        rsp_status <= ST_TIMEOUT;
                        rsp_data   <= '0;
                    end else if (!Sl_toutSup) begin
                        tout_cnt <= tout_cnt + TOUT_W'(1);
                    end
                end

                S_BACKOFF: begin
                    state    <= S_BUS;
                    tout_cnt <= '0;
                    M_select <= 1'b1;
                    M_ABus   <= addr_q;
                    M_BE     <= 4'b1111;
                    M_DBus   <= rnw_q ? 32'd0 : data_q;
                    M_RNW    <= rnw_q;
                end

                S_RESP: begin
                    if (rsp_ready) begin
                        state      <= S_IDLE;
                        rsp_valid  <= 1'b0;
                        rsp_status <= '0;
                        rsp_data   <= '0;
                        cmd_ready  <= 1'b1;
                        tout_cnt   <= '0;
                        retry_cnt  <= '0;
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_opb_reg_cfg_sequencer.sv
// Directed bench for opb_reg_cfg_sequencer with a scripted OPB slave.
module tb_opb_reg_cfg_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_rnw = 1'b0;
    logic [31:0] cmd_addr = '0;
    logic [31:0] cmd_data = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [2:0]  rsp_status;
    logic [31:0] rsp_data;
    logic [0:31] M_ABus;
    logic [0:3]  M_BE;
    logic [0:31] M_DBus;
    logic        M_RNW;
    logic        M_select;
    logic        M_seqAddr;
    logic [0:31] Sl_DBus = '0;
    logic        Sl_xferAck = 1'b0;
    logic        Sl_errAck = 1'b0;
    logic        Sl_retry = 1'b0;
    logic        Sl_toutSup = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    int          sel_total;
    int          rsp_cyc;
    logic [31:0] pat;
    logic        bus_ok;
    logic        stable_ok;

    always #5 clk = ~clk;

    opb_reg_cfg_sequencer dut (
        .OPB_Clk    (clk),
        .OPB_Rst_n  (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_rnw    (cmd_rnw),
        .cmd_addr   (cmd_addr),
        .cmd_data   (cmd_data),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_status (rsp_status),
        .rsp_data   (rsp_data),
        .M_ABus     (M_ABus),
        .M_BE       (M_BE),
        .M_DBus     (M_DBus),
        .M_RNW      (M_RNW),
        .M_select   (M_select),
        .M_seqAddr  (M_seqAddr),
        .Sl_DBus    (Sl_DBus),
        .Sl_xferAck (Sl_xferAck),
        .Sl_errAck  (Sl_errAck),
        .Sl_retry   (Sl_retry),
        .Sl_toutSup (Sl_toutSup)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one command and play the slave until rsp_valid shows up.
    // ack_at: select cycle within a burst that acks (0 = never).
    // n_retry: bursts answered with retry on their first cycle.
    // sup_n: toutSup held high for the first sup_n select cycles.
    task automatic run_cmd(input logic rnw, input logic [31:0] addr, input logic [31:0] data,
                           input int ack_at, input logic do_xfer, input logic do_err,
                           input logic [31:0] rd_val, input int n_retry, input int sup_n);
        int burst;
        int retries;
        sel_total = 0;
        rsp_cyc   = -1;
        pat       = '0;
        bus_ok    = 1'b1;
        burst     = 0;
        retries   = 0;
        rsp_ready = 1'b0;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_rnw   = rnw;
        cmd_addr  = addr;
        cmd_data  = data;
        @(posedge clk);
        for (int cyc = 1; cyc <= 200; cyc++) begin
            @(negedge clk);
            cmd_valid  = 1'b0;
            Sl_xferAck = 1'b0;
            Sl_errAck  = 1'b0;
            Sl_retry   = 1'b0;
            Sl_toutSup = 1'b0;
            Sl_DBus    = '0;
            if (rsp_valid) begin
                rsp_cyc = cyc;
                break;
            end
            pat = {pat[30:0], M_select};
            if (M_select) begin
                sel_total++;
                burst++;
                if (M_ABus !== addr || M_BE !== 4'b1111 || M_RNW !== rnw ||
                    M_DBus !== (rnw ? 32'd0 : data))
                    bus_ok = 1'b0;
                Sl_toutSup = (sel_total <= sup_n);
                if (retries < n_retry && burst == 1) begin
                    Sl_retry = 1'b1;
                    retries++;
                end else if (ack_at != 0 && burst == ack_at) begin
                    Sl_xferAck = do_xfer;
                    Sl_errAck  = do_err;
                    Sl_DBus    = rd_val;
                end
            end else begin
                burst = 0;
                if (M_ABus !== '0 || M_BE !== '0 || M_DBus !== '0 || M_RNW !== 1'b0)
                    bus_ok = 1'b0;
            end
        end
    endtask

    task automatic consume(input string tag);
        @(negedge clk);
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        check({tag, "_rsp_valid_cleared"}, 32'(rsp_valid), 32'd0);
        check({tag, "_cmd_ready_back"}, 32'(cmd_ready), 32'd1);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("reset_cmd_ready", 32'(cmd_ready), 32'd1);
        check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset_select", 32'(M_select), 32'd0);
        check("reset_abus", M_ABus, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_reset_status", 32'(rsp_status), 32'd0);
        check("post_reset_data", rsp_data, 32'd0);
        check("seqaddr_tied", 32'(M_seqAddr), 32'd0);

        // Write with immediate ack
        run_cmd(1'b0, 32'h010B0004, 32'hDEADBEEF, 1, 1'b1, 1'b0, 32'h0, 0, 0);
        check("wr_rsp_cycle", 32'(rsp_cyc), 32'd2);
        check("wr_sel_cycles", 32'(sel_total), 32'd1);
        check("wr_bus_values", 32'(bus_ok), 32'd1);
        check("wr_status", 32'(rsp_status), 32'd0);
        check("wr_data", rsp_data, 32'd0);
        consume("wr");

        // Read, ack on the 4th select cycle
        run_cmd(1'b1, 32'h010B0000, 32'h0, 4, 1'b1, 1'b0, 32'h12345678, 0, 0);
        check("rd_rsp_cycle", 32'(rsp_cyc), 32'd5);
        check("rd_sel_cycles", 32'(sel_total), 32'd4);
        check("rd_bus_values", 32'(bus_ok), 32'd1);
        check("rd_status", 32'(rsp_status), 32'd0);
        check("rd_data", rsp_data, 32'h12345678);
        consume("rd");

        // Out of window above HIGHADDR
        run_cmd(1'b0, 32'h010C0000, 32'h5555AAAA, 1, 1'b1, 1'b0, 32'h0, 0, 0);
        check("oow_rsp_cycle", 32'(rsp_cyc), 32'd1);
        check("oow_sel_cycles", 32'(sel_total), 32'd0);
        check("oow_status", 32'(rsp_status), 32'd4);
        consume("oow");

        // Just below BASEADDR
        run_cmd(1'b1, 32'h010AFFFF, 32'h0, 1, 1'b1, 1'b0, 32'hFFFFFFFF, 0, 0);
        check("below_sel_cycles", 32'(sel_total), 32'd0);
        check("below_status", 32'(rsp_status), 32'd4);
        check("below_data", rsp_data, 32'd0);
        consume("below");

        // HIGHADDR itself is legal
        run_cmd(1'b0, 32'h010B00FF, 32'h00C0FFEE, 1, 1'b1, 1'b0, 32'h0, 0, 0);
        check("high_sel_cycles", 32'(sel_total), 32'd1);
        check("high_status", 32'(rsp_status), 32'd0);
        check("high_bus_values", 32'(bus_ok), 32'd1);
        consume("high");

        // Two retries then ack
        run_cmd(1'b0, 32'h010B0010, 32'hA5A5A5A5, 1, 1'b1, 1'b0, 32'h0, 2, 0);
        check("retry_pattern", pat, 32'b10101);
        check("retry_rsp_cycle", 32'(rsp_cyc), 32'd6);
        check("retry_bus_values", 32'(bus_ok), 32'd1);
        check("retry_status", 32'(rsp_status), 32'd0);
        consume("retry");

        // Retry exhaustion
        run_cmd(1'b0, 32'h010B0020, 32'h01020304, 0, 1'b0, 1'b0, 32'h0, 5, 0);
        check("rexh_sel_cycles", 32'(sel_total), 32'd5);
        check("rexh_rsp_cycle", 32'(rsp_cyc), 32'd10);
        check("rexh_status", 32'(rsp_status), 32'd3);
        consume("rexh");

        // Timeout with no ack
        run_cmd(1'b0, 32'h010B0030, 32'h11112222, 0, 1'b0, 1'b0, 32'h0, 0, 0);
        check("tout_sel_cycles", 32'(sel_total), 32'd16);
        check("tout_rsp_cycle", 32'(rsp_cyc), 32'd17);
        check("tout_status", 32'(rsp_status), 32'd2);
        consume("tout");

        // Timeout stretched by toutSup for 10 cycles
        run_cmd(1'b1, 32'h010B0034, 32'h0, 0, 1'b0, 1'b0, 32'h0, 0, 10);
        check("tsup_sel_cycles", 32'(sel_total), 32'd26);
        check("tsup_status", 32'(rsp_status), 32'd2);
        check("tsup_data", rsp_data, 32'd0);
        consume("tsup");

        // Ack in the same cycle the timeout would fire
        run_cmd(1'b1, 32'h010B0038, 32'h0, 16, 1'b1, 1'b0, 32'hCAFEF00D, 0, 0);
        check("tack_sel_cycles", 32'(sel_total), 32'd16);
        check("tack_status", 32'(rsp_status), 32'd0);
        check("tack_data", rsp_data, 32'hCAFEF00D);
        consume("tack");

        // errAck together with xferAck on a read
        run_cmd(1'b1, 32'h010B0040, 32'h0, 2, 1'b1, 1'b1, 32'h87654321, 0, 0);
        check("err_sel_cycles", 32'(sel_total), 32'd2);
        check("err_status", 32'(rsp_status), 32'd1);
        check("err_data", rsp_data, 32'd0);

        // Response holds while rsp_ready stays low for 5 cycles
        stable_ok = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (rsp_valid !== 1'b1 || rsp_status !== 3'd1 || rsp_data !== 32'd0 ||
                cmd_ready !== 1'b0 || M_select !== 1'b0)
                stable_ok = 1'b0;
        end
        check("hold_stable", 32'(stable_ok), 32'd1);
        consume("hold");

        // Reset in the middle of a bus cycle
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_rnw   = 1'b0;
        cmd_addr  = 32'h010B0050;
        cmd_data  = 32'h0BADF00D;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        check("mid_select_up", 32'(M_select), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_select_async_drop", 32'(M_select), 32'd0);
        check("mid_abus_cleared", M_ABus, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("mid_no_response", 32'(rsp_valid), 32'd0);
        check("mid_cmd_ready", 32'(cmd_ready), 32'd1);

        // A normal command still works afterwards
        run_cmd(1'b0, 32'h010B0060, 32'h13572468, 1, 1'b1, 1'b0, 32'h0, 0, 0);
        check("after_rst_rsp_cycle", 32'(rsp_cyc), 32'd2);
        check("after_rst_status", 32'(rsp_status), 32'd0);
        consume("after_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
